swc_rtu_rsp_feeder: RTL and testbench
=====================================

# swc_rtu_rsp_feeder

Parametrised RTU-response queueing stage between the routing-table model and the swc_core RTU input, for any number of switch ports. Each port has its own response FIFO. Each FIFO presents its head entry on the swc_core `rtu_rsp_valid`/`rtu_rsp_ack` handshake. The block also provides per-port flush, full indication and saturating overflow counters. Testbenches use it to queue back-to-back RTU decisions ahead of frame traffic.

## Interface
Parameters:
- g_num_ports, 7 — number of switch ports N
- g_prio_width, 3 — priority width P
- g_fifo_depth, 4 — entries per port FIFO D; power of two, ≥2
- g_ovf_cnt_width, 8 — overflow counter width C

Ports:
- clk_i  in  1  — single clock
- rst_n_i  in  1  — reset, asynchronous, active-low
- req_valid_i  in  N  — per-port push strobe
- req_dst_port_mask_i  in  N*N  — port i mask in bits [i*N +: N]
- req_drop_i  in  N  — per-port drop flag
- req_prio_i  in  N*P  — port i prio in bits [i*P +: P]
- req_full_o  out  N  — FIFO i holds D entries
- flush_i  in  N  — per-port synchronous FIFO clear
- ovf_clr_i  in  1  — clears all overflow counters
- ovf_cnt_o  out  N*C  — port i counter in bits [i*C +: C]
- rtu_rsp_valid_o  out  N  — head entry valid, to swc_core `rtu_rsp_valid_i`
- rtu_rsp_ack_i  in  N  — from swc_core `rtu_rsp_ack_o`
- rtu_dst_port_mask_o  out  N*N  — head entry mask
- rtu_drop_o  out  N  — head entry drop
- rtu_prio_o  out  N*P  — head entry prio

## Operation
- N independent, identical channels. An entry is {mask, drop, prio}, N+1+P bits.
- Each channel has a write pointer, a read pointer (each log2(D) bits, wrapping modulo D) and an occupancy count (log2(D)+1 bits, range 0..D).
- Push accepted: req_valid_i[i]=1, flush_i[i]=0 and count<D.
  - Entry is written at the write pointer; the write pointer increments.
- Push rejected: req_valid_i[i]=1 while count==D.
  - Entry is discarded.
  - ovf_cnt[i] increments, saturating at 2^C−1.
  - Full is judged on the registered count. A push is rejected even if a pop occurs in the same cycle.
- Pop: rtu_rsp_valid_o[i]=1 and rtu_rsp_ack_i[i]=1. The read pointer increments.
  - An ack while valid=0 is ignored.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- flush_i[i]=1:
  - Pointers and count go to 0 at the next edge.
  - A same-cycle push is discarded and not counted as overflow.
  - A same-cycle ack is ignored.
- ovf_clr_i=1 zeroes all counters. Overflow events in that same cycle are lost; clear wins.
- Outputs:
  - rtu_rsp_valid_o[i] = (count≠0).
  - Head fields are the entry at the read pointer when valid=1, and all-zero when valid=0.
  - Head fields stay stable while valid=1 and ack=0.
- Ordering: strict FIFO per channel. Channels never interact.

## Timing
- Reset values: req_full_o=0, ovf_cnt_o=0, rtu_rsp_valid_o=0, rtu_dst_port_mask_o=0, rtu_drop_o=0, rtu_prio_o=0; all pointers and counts are 0.
- Reset is asynchronous and takes effect immediately. Deassertion mid-traffic restarts all channels empty, with no spurious valid.
- Push-to-valid latency: push sampled at edge k → rtu_rsp_valid_o=1 and head data valid after edge k.
- Ack sampled at edge k → the next entry, if any, is presented after edge k. This gives one response per cycle sustained.
- req_full_o and the outputs are registered, or are combinational decodes of registered state only. No combinational path exists from any input to any output.
- A FIFO memory of D entries with registered pointers is acceptable. The read is asynchronous from the register array.

## Test plan
1. Reset, then push one entry on port 2 (mask 0x05, drop 0, prio 3) → rtu_rsp_valid_o=0x04 on the next cycle with mask 0x05, prio 3; ack one cycle → valid returns to 0; other ports stay idle.
2. Push D=4 entries on port 0 (prio 0..3) with ack low → req_full_o[0]=1; a 5th push → ovf_cnt[0]=1, FIFO contents unchanged; ack four cycles → prio 0,1,2,3 in order, then valid 0.
3. Full FIFO, push and ack in the same cycle → push rejected, ovf_cnt increments, count drops to 3. Half-full FIFO, push and ack together → count unchanged, order preserved across pointer wrap (≥10 entries streamed).
4. 300 rejected pushes → ovf_cnt saturates at 255; ovf_clr_i → 0 next cycle.
5. Port 3 holding 2 entries, assert flush_i[3] together with push and ack → next cycle valid[3]=0, full[3]=0, ovf_cnt[3] unchanged; port 4 traffic unaffected.
6. All 7 ports pushing and acking every cycle with random stalls, then rst_n_i asserted mid-stream → all outputs zero immediately; after release, a scoreboard shows per-port order and data match with no loss for accepted pushes.

Source files
------------

// File: rtl/swc_rtu_rsp_feeder.sv
// Per-port RTU response FIFOs feeding swc_core's rtu_rsp_valid/ack handshake.
// Each channel also has a flush input, a full flag and a saturating overflow counter.
module swc_rtu_rsp_feeder #(
    parameter int g_num_ports     = 7,
    parameter int g_prio_width    = 3,
    parameter int g_fifo_depth    = 4,
    parameter int g_ovf_cnt_width = 8
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic [g_num_ports-1:0]               req_valid_i,
    input  logic [g_num_ports*g_num_ports-1:0]   req_dst_port_mask_i,
    input  logic [g_num_ports-1:0]               req_drop_i,
    input  logic [g_num_ports*g_prio_width-1:0]  req_prio_i,
    output logic [g_num_ports-1:0]               req_full_o,
    input  logic [g_num_ports-1:0]               flush_i,
    input  logic                                 ovf_clr_i,
    output logic [g_num_ports*g_ovf_cnt_width-1:0] ovf_cnt_o,
    output logic [g_num_ports-1:0]               rtu_rsp_valid_o,
    input  logic [g_num_ports-1:0]               rtu_rsp_ack_i,
    output logic [g_num_ports*g_num_ports-1:0]   rtu_dst_port_mask_o,
    output logic [g_num_ports-1:0]               rtu_drop_o,
    output logic [g_num_ports*g_prio_width-1:0]  rtu_prio_o
);

    localparam int N  = g_num_ports;
    localparam int P  = g_prio_width;
    localparam int D  = g_fifo_depth;
    localparam int C  = g_ovf_cnt_width;
    localparam int AW = $clog2(D);
    localparam int EW = N + 1 + P;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(D);

    function automatic logic [C-1:0] sat_inc(input logic [C-1:0] v);
        sat_inc = (v == {C{1'b1}}) ? v : v + 1'b1;
    endfunction

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic [AW-1:0] wr_ptr_q, wr_ptr_d;
        logic [AW-1:0] rd_ptr_q, rd_ptr_d;
        logic [AW:0]   count_q, count_d;
        logic [C-1:0]  ovf_q, ovf_d;
        logic [EW-1:0] mem_q [D];

        logic          full;
        logic          valid;
        logic          push_acc;
        logic          pop;
        logic          ovf_evt;
        logic [EW-1:0] wr_entry;
        logic [EW-1:0] head;

        assign wr_entry = {req_dst_port_mask_i[i*N +: N], req_drop_i[i], req_prio_i[i*P +: P]};

        // Full is taken from the registered count, so a same-cycle pop never frees a slot.
        assign full     = (count_q == FULL_CNT);
        assign valid    = (count_q != '0);
        assign push_acc = req_valid_i[i] & ~flush_i[i] & ~full;
        assign pop      = valid & rtu_rsp_ack_i[i] & ~flush_i[i];
        assign ovf_evt  = req_valid_i[i] & ~flush_i[i] & full;

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (flush_i[i]) begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                count_d  = '0;
            end else begin
                if (push_acc) begin
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
                unique case ({push_acc, pop})
                    2'b10:   count_d = count_q + 1'b1;
                    2'b01:   count_d = count_q - 1'b1;
                    default: count_d = count_q;
                endcase
            end
        end

        always_comb begin
            ovf_d = ovf_q;
            if (ovf_clr_i) begin
                ovf_d = '0;
            end else if (ovf_evt) begin
                ovf_d = sat_inc(ovf_q);
            end
        end

        always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
                ovf_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
                ovf_q    <= ovf_d;
            end
        end

        // Storage carries no reset; the head is masked to zero whenever the FIFO is empty.
        always_ff @(posedge clk_i) begin
            if (push_acc) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end

        assign head = valid ? mem_q[rd_ptr_q] : '0;

        assign req_full_o[i]                = full;
        assign rtu_rsp_valid_o[i]           = valid;
        assign ovf_cnt_o[i*C +: C]          = ovf_q;
        assign rtu_dst_port_mask_o[i*N +: N] = head[EW-1 -: N];
        assign rtu_drop_o[i]                = head[P];
        assign rtu_prio_o[i*P +: P]         = head[P-1:0];
    end

endmodule

// File: tb/tb_swc_rtu_rsp_feeder.sv
// Scoreboard bench for swc_rtu_rsp_feeder: directed scenarios plus randomized traffic
// with a mid-stream reset, checked against per-port queue models.
module tb_swc_rtu_rsp_feeder;

    localparam int N = 7;
    localparam int P = 3;
    localparam int D = 4;
    localparam int C = 8;
    localparam int OVF_MAX = (1 << C) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     req_valid;
    logic [N*N-1:0]   req_mask;
    logic [N-1:0]     req_drop;
    logic [N*P-1:0]   req_prio;
    logic [N-1:0]     req_full;
    logic [N-1:0]     flush;
    logic             ovf_clr;
    logic [N*C-1:0]   ovf_cnt;
    logic [N-1:0]     rsp_valid;
    logic [N-1:0]     rsp_ack;
    logic [N*N-1:0]   rsp_mask;
    logic [N-1:0]     rsp_drop;
    logic [N*P-1:0]   rsp_prio;

    always #5 clk = ~clk;

    swc_rtu_rsp_feeder #(
        .g_num_ports(N), .g_prio_width(P), .g_fifo_depth(D), .g_ovf_cnt_width(C)
    ) dut (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .req_valid_i        (req_valid),
        .req_dst_port_mask_i(req_mask),
        .req_drop_i         (req_drop),
        .req_prio_i         (req_prio),
        .req_full_o         (req_full),
        .flush_i            (flush),
        .ovf_clr_i          (ovf_clr),
        .ovf_cnt_o          (ovf_cnt),
        .rtu_rsp_valid_o    (rsp_valid),
        .rtu_rsp_ack_i      (rsp_ack),
        .rtu_dst_port_mask_o(rsp_mask),
        .rtu_drop_o         (rsp_drop),
        .rtu_prio_o         (rsp_prio)
    );

    typedef struct packed {
        logic [N-1:0] mask;
        logic         drop;
        logic [P-1:0] prio;
    } ent_t;

    ent_t exp_q [N][$];
    int   ovf_m [N];
    bit   popped [N];
    bit   mon_en = 1'b0;
    int   vectors = 0;
    int   errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic clr_in();
        req_valid = '0;
        req_mask  = '0;
        req_drop  = '0;
        req_prio  = '0;
        flush     = '0;
        ovf_clr   = 1'b0;
        rsp_ack   = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            exp_q[i].delete();
            ovf_m[i]  = 0;
            popped[i] = 1'b0;
        end
    endtask

    // Applies the inputs held during the cycle that just ended to the reference queues.
    task automatic model_edge();
        bit ev [N];
        for (int i = 0; i < N; i++) begin
            int   occ;
            ent_t e;
            ev[i] = 1'b0;
            if (flush[i]) begin
                exp_q[i].delete();
            end else begin
                occ = exp_q[i].size() + (popped[i] ? 1 : 0);
                if (req_valid[i]) begin
                    if (occ < D) begin
                        e.mask = req_mask[i*N +: N];
                        e.drop = req_drop[i];
                        e.prio = req_prio[i*P +: P];
                        exp_q[i].push_back(e);
                    end else begin
                        ev[i] = 1'b1;
                    end
                end
            end
            popped[i] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (ovf_clr) ovf_m[i] = 0;
            else if (ev[i] && ovf_m[i] < OVF_MAX) ovf_m[i]++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic push(input int p, input logic [N-1:0] m, input logic d, input logic [P-1:0] pr);
        req_valid[p]       = 1'b1;
        req_mask[p*N +: N] = m;
        req_drop[p]        = d;
        req_prio[p*P +: P] = pr;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, " valid"}, 64'(rsp_valid), 64'd0);
        chk({nm, " full"},  64'(req_full),  64'd0);
        chk({nm, " ovf"},   64'(ovf_cnt),   64'd0);
        chk({nm, " mask"},  64'(rsp_mask),  64'd0);
        chk({nm, " drop"},  64'(rsp_drop),  64'd0);
        chk({nm, " prio"},  64'(rsp_prio),  64'd0);
    endtask

    // Monitor: compares every port's presented head against the scoreboard front.
    always @(negedge clk) begin : mon
        ent_t e;
        bit   ev;
        if (mon_en && rst_n) begin
            for (int i = 0; i < N; i++) begin
                ev = (exp_q[i].size() != 0);
                e  = ev ? exp_q[i][0] : '0;
                chk($sformatf("valid[%0d]", i), 64'(rsp_valid[i]), 64'(ev));
                chk($sformatf("full[%0d]", i),  64'(req_full[i]),  64'(exp_q[i].size() == D));
                chk($sformatf("ovf[%0d]", i),   64'(ovf_cnt[i*C +: C]), 64'(ovf_m[i]));
                chk($sformatf("mask[%0d]", i),  64'(rsp_mask[i*N +: N]), 64'(e.mask));
                chk($sformatf("drop[%0d]", i),  64'(rsp_drop[i]),  64'(e.drop));
                chk($sformatf("prio[%0d]", i),  64'(rsp_prio[i*P +: P]), 64'(e.prio));
                if (ev && rsp_ack[i] && !flush[i]) begin
                    e = exp_q[i].pop_front();
                    popped[i] = 1'b1;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        clr_in();
        model_reset();
        #1;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Single entry on port 2
        push(2, 7'h05, 1'b0, 3'd3);
        step();
        clr_in();
        chk("t1 valid", 64'(rsp_valid), 64'h04);
        chk("t1 mask", 64'(rsp_mask), 64'h5 << 14);
        chk("t1 prio", 64'(rsp_prio[2*P +: P]), 64'd3);
        rsp_ack[2] = 1'b1;
        step();
        clr_in();
        chk("t1 valid after ack", 64'(rsp_valid), 64'h00);

        // Fill port 0, overflow, drain in order
        for (int k = 0; k < D; k++) begin
            push(0, N'($urandom), 1'($urandom), P'(k));
            step();
            clr_in();
        end
        chk("t2 full", 64'(req_full[0]), 64'd1);
        push(0, '1, 1'b1, 3'd7);
        step();
        clr_in();
        chk("t2 ovf", 64'(ovf_cnt[0 +: C]), 64'd1);
        for (int k = 0; k < D; k++) begin
            chk($sformatf("t2 order %0d", k), 64'(rsp_prio[0 +: P]), 64'(k));
            rsp_ack[0] = 1'b1;
            step();
            clr_in();
        end
        chk("t2 drained", 64'(rsp_valid[0]), 64'd0);

        // Full FIFO with simultaneous push and ack
        for (int k = 0; k < D; k++) begin
            push(0, N'($urandom), 1'b0, P'(k));
            step();
            clr_in();
        end
        push(0, '1, 1'b1, 3'd7);
        rsp_ack[0] = 1'b1;
        step();
        clr_in();
        chk("t3 ovf", 64'(ovf_cnt[0 +: C]), 64'd2);
        chk("t3 full", 64'(req_full[0]), 64'd0);
        chk("t3 head", 64'(rsp_prio[0 +: P]), 64'd1);
        for (int k = 0; k < 3; k++) begin
            rsp_ack[0] = 1'b1;
            step();
            clr_in();
        end
        // Half full, streaming across pointer wrap
        for (int k = 0; k < 2; k++) begin
            push(0, N'($urandom), 1'($urandom), P'(k));
            step();
            clr_in();
        end
        for (int k = 2; k < 14; k++) begin
            push(0, N'($urandom), 1'($urandom), P'(k % 8));
            rsp_ack[0] = 1'b1;
            step();
            clr_in();
        end
        chk("t3 stream valid", 64'(rsp_valid[0]), 64'd1);
        chk("t3 stream full", 64'(req_full[0]), 64'd0);
        chk("t3 stream head", 64'(rsp_prio[0 +: P]), 64'd4);
        for (int k = 0; k < 2; k++) begin
            rsp_ack[0] = 1'b1;
            step();
            clr_in();
        end

        // Overflow counter saturation and clear
        for (int k = 0; k < D; k++) begin
            push(1, N'($urandom), 1'b0, P'(k));
            step();
            clr_in();
        end
        for (int k = 0; k < 300; k++) begin
            push(1, N'($urandom), 1'b1, 3'd5);
            step();
        end
        clr_in();
        chk("t4 saturate", 64'(ovf_cnt[C +: C]), 64'd255);
        ovf_clr = 1'b1;
        step();
        clr_in();
        chk("t4 clear", 64'(ovf_cnt), 64'd0);
        for (int k = 0; k < D; k++) begin
            rsp_ack[1] = 1'b1;
            step();
            clr_in();
        end

        // Flush on port 3 with push and ack; port 4 keeps running
        for (int k = 0; k < 2; k++) begin
            push(3, N'($urandom), 1'b0, P'(k + 1));
            if (k == 0) push(4, 7'h11, 1'b1, 3'd6);
            step();
            clr_in();
        end
        flush[3]   = 1'b1;
        rsp_ack[3] = 1'b1;
        push(3, '1, 1'b1, 3'd7);
        push(4, 7'h22, 1'b0, 3'd2);
        step();
        clr_in();
        chk("t5 valid3", 64'(rsp_valid[3]), 64'd0);
        chk("t5 full3", 64'(req_full[3]), 64'd0);
        chk("t5 ovf3", 64'(ovf_cnt[3*C +: C]), 64'd0);
        chk("t5 valid4", 64'(rsp_valid[4]), 64'd1);
        chk("t5 head4", 64'(rsp_mask[4*N +: N]), 64'h11);
        for (int k = 0; k < 2; k++) begin
            rsp_ack[4] = 1'b1;
            step();
            clr_in();
        end
        chk("t5 idle", 64'(rsp_valid), 64'd0);

        // Random traffic on all ports with a mid-stream reset
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i]       = ($urandom_range(0, 99) < 60);
                req_mask[i*N +: N] = N'($urandom);
                req_drop[i]        = 1'($urandom);
                req_prio[i*P +: P] = P'($urandom);
                rsp_ack[i]         = ($urandom_range(0, 99) < 70);
                flush[i]           = ($urandom_range(0, 63) == 0);
            end
            ovf_clr = ($urandom_range(0, 127) == 0);
            step();
            if (c == 300) begin
                #2;
                rst_n = 1'b0;
                clr_in();
                #1;
                chk_all_zero("midreset");
                model_reset();
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        clr_in();
        for (int k = 0; k < D + 4; k++) begin
            rsp_ack = '1;
            step();
        end
        clr_in();
        chk("final idle", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
